// File: rtl/gcd_operand_sequencer.sv
// gcd_operand_sequencer: feeds operand pairs from a valid/ready stream into the
// subtractive GCD core. A is on the shared bus during the start pulse and B on
// the cycle after. The block then waits for done under a cycle limit and hands
// the result downstream. Zero operands are answered here and never reach the
// core, because the core would not terminate on them.
module gcd_operand_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] gcd_data_in,
  output logic             gcd_start,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, RUN, HOLD} state_t;

  // The last RUN cycle has counter value TIMEOUT-1, which gives exactly
  // TIMEOUT RUN cycles before the abort.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CNT_W-1:0]   cnt;

  // Sequencer FSM. Each output is loaded with the value it must have in the
  // state being entered, so no input reaches an output in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt         <= '0;
      in_ready    <= 1'b1;
      gcd_start   <= 1'b0;
      gcd_data_in <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q         <= in_a;
            b_q         <= in_b;
            gcd_data_in <= in_a;
            in_ready    <= 1'b0;
            if (in_a != '0 && in_b != '0) begin
              gcd_start <= 1'b1;
              state     <= LOAD_A;
            end else begin
              // gcd(x,0) = x; both zero has no answer and is flagged.
              out_result <= (in_a != '0) ? in_a : in_b;
              out_err    <= (in_a == '0) && (in_b == '0);
              out_valid  <= 1'b1;
              state      <= HOLD;
            end
          end
        end
        LOAD_A: begin
          // The core latches A on this edge. B goes on the bus next.
          gcd_start   <= 1'b0;
          gcd_data_in <= b_q;
          state       <= LOAD_B;
        end
        LOAD_B: begin
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          // On the first RUN cycle, done can still be high from the previous run.
          if (cnt != '0 && gcd_done) begin
            out_result <= gcd_result;
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end else if (cnt == CNT_LAST) begin
            out_result <= '0;
            out_err    <= 1'b1;
            out_valid  <= 1'b1;
            state      <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            gcd_data_in <= a_q;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
